// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order queue of in-flight branch predictions.
// Each resolve pops the oldest entry and emits a one-cycle predictor update.
// A mispredicting resolve flushes everything younger, including any
// same-cycle enqueue, because those entries sit on the wrong path.
module branch_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 8,
  parameter int GHR_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pred_valid,
  output logic                     pred_ready,
  input  logic [PC_W-1:0]          pred_pc,
  input  logic                     pred_taken,
  input  logic [GHR_W-1:0]         pred_ghr,
  input  logic                     resolve_valid,
  input  logic                     resolve_taken,
  output logic                     upd_valid,
  output logic [PC_W-1:0]          upd_pc,
  output logic [GHR_W-1:0]         upd_ghr,
  output logic                     upd_outcome,
  output logic                     mispredict,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     underflow_err,
  output logic [15:0]              correct_cnt,
  output logic [15:0]              mispred_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // Entry store: not reset, validity is tracked by head/tail/count.
  logic [PC_W-1:0]  mem_pc    [DEPTH];
  logic             mem_taken [DEPTH];
  logic [GHR_W-1:0] mem_ghr   [DEPTH];

  logic [PW-1:0] head_reg;
  logic [PW-1:0] tail_reg;
  logic [CW-1:0] count_reg;

  logic push;
  logic pop;
  logic flush;
  logic push_eff;

  // Handshake and resolve decode; a full queue never admits a push even if
  // the head is popped in the same cycle.
  always_comb begin
    pred_ready = (count_reg != FULL_COUNT);
    push       = pred_valid && pred_ready;
    pop        = resolve_valid && (count_reg != '0);
    flush      = pop && (mem_taken[head_reg] != resolve_taken);
    push_eff   = push && !flush;
  end

  assign count = count_reg;

  // Write the incoming prediction at the tail slot.
  always_ff @(posedge clk) begin
    if (push_eff) begin
      mem_pc[tail_reg]    <= pred_pc;
      mem_taken[tail_reg] <= pred_taken;
      mem_ghr[tail_reg]   <= pred_ghr;
    end
  end

  // Pointer and occupancy tracking, with flush on mispredict.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push_eff) tail_reg <= tail_reg + PW'(1);
      if (pop)      head_reg <= head_reg + PW'(1);
      if (push_eff && !pop)      count_reg <= count_reg + CW'(1);
      else if (pop && !push_eff) count_reg <= count_reg - CW'(1);
    end
  end

  // Registered predictor update; payload holds its value between pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      upd_valid   <= 1'b0;
      mispredict  <= 1'b0;
      upd_pc      <= '0;
      upd_ghr     <= '0;
      upd_outcome <= 1'b0;
    end else begin
      upd_valid  <= pop;
      mispredict <= flush;
      if (pop) begin
        upd_pc      <= mem_pc[head_reg];
        upd_ghr     <= mem_ghr[head_reg];
        upd_outcome <= resolve_taken;
      end
    end
  end

  // Sticky underflow flag and saturating accuracy counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      underflow_err <= 1'b0;
      correct_cnt   <= '0;
      mispred_cnt   <= '0;
    end else begin
      if (resolve_valid && (count_reg == '0)) underflow_err <= 1'b1;
      if (flush) begin
        if (mispred_cnt != 16'hFFFF) mispred_cnt <= mispred_cnt + 16'd1;
      end else if (pop) begin
        if (correct_cnt != 16'hFFFF) correct_cnt <= correct_cnt + 16'd1;
      end
    end
  end

endmodule
